// File: rtl/crc_fsk4_pkg.sv
// Shared types for the CRC/4FSK framer: FSM states, tone indices and the dibit-to-tone Gray map.
// No logic latency; pure declarations.
// No handshake; pure declarations.
package crc_fsk4_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        CRC  = 2'd3
    } state_t;

    localparam logic [1:0] TONE_0 = 2'd0;
    localparam logic [1:0] TONE_1 = 2'd1;
    localparam logic [1:0] TONE_2 = 2'd2;
    localparam logic [1:0] TONE_3 = 2'd3;

    // Adjacent tones differ by one bit, so a one-tone detection slip costs a single bit error.
    function automatic logic [1:0] gray_map(input logic [1:0] dibit);
        case (dibit)
            2'b00:   return TONE_0;
            2'b01:   return TONE_1;
            2'b11:   return TONE_2;
            default: return TONE_3;
        endcase
    endfunction

endpackage

// File: rtl/crc_fsk4_crc.sv
// Parallel CRC update: DATA_W serial MSB-first shifts collapsed into one combinational step.
// Latency: combinational, zero cycles.
// No handshake; the caller decides when to register crc_out.
module crc_fsk4_crc #(
    parameter int               DATA_W   = 8,
    parameter int               CRC_W    = 8,
    parameter logic [CRC_W-1:0] CRC_POLY = CRC_W'('h07)
) (
    input  logic [CRC_W-1:0]  crc_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [CRC_W-1:0]  crc_out
);

    logic [CRC_W-1:0] c;
    logic             fb;

    always_comb begin
        c  = crc_in;
        fb = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = c[CRC_W-1] ^ data_in[i];
            c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
        end
        crc_out = c;
    end

endmodule

// File: rtl/crc_fsk4_framer.sv
// crc_fsk4_framer: appends a CRC to a word frame and serialises it as Gray-coded 4FSK tone indices (preamble with CRC_FSK_PREAMBLE_EN).
// Latency: word accepted at edge t gives out_valid at t+1; symbols stream back-to-back while words keep arriving.
// Backpressure: symbols advance only on out_valid & out_ready; in_ready holds off until the held word is fully shifted out.
module crc_fsk4_framer
    import crc_fsk4_pkg::*;
#(
    parameter int               DATA_W        = 8,
    parameter int               CRC_W         = 8,
    parameter logic [CRC_W-1:0] CRC_POLY      = CRC_W'('h07),
    parameter logic [CRC_W-1:0] CRC_INIT      = '0,
    parameter logic [CRC_W-1:0] CRC_XOROUT    = '0,
    parameter int               PREAMBLE_SYMS = 8
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [1:0]        out_tone,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic [CRC_W-1:0]  crc_value,
    output logic              busy
);

    localparam int SR_W  = (DATA_W > CRC_W) ? DATA_W : CRC_W;
    localparam int CNT_W = $clog2(SR_W / 2 + 1);
    localparam logic [CNT_W-1:0] SYM_DATA = CNT_W'(DATA_W / 2);
    localparam logic [CNT_W-1:0] SYM_CRC  = CNT_W'(CRC_W / 2);
    localparam logic [CNT_W-1:0] SYM_ONE  = CNT_W'(1);

    if ((DATA_W % 2) != 0 || DATA_W < 2) begin : g_bad_data_w
        $error("crc_fsk4_framer: DATA_W must be even and >= 2");
    end
    if ((CRC_W % 2) != 0 || CRC_W < 2 || CRC_W > 32) begin : g_bad_crc_w
        $error("crc_fsk4_framer: CRC_W must be even and in 2..32");
    end
    if (PREAMBLE_SYMS < 1) begin : g_bad_pre
        $error("crc_fsk4_framer: PREAMBLE_SYMS must be >= 1");
    end

    state_t           state;
    logic [SR_W-1:0]  sr;
    logic [CNT_W-1:0] sym_cnt;
    logic             last_word;
    logic [CRC_W-1:0] crc_reg;
    logic [CRC_W-1:0] crc_next;
    logic [SR_W-1:0]  word_al;
    logic [SR_W-1:0]  crc_al;
    logic             in_fire;
    logic             out_fire;

`ifdef CRC_FSK_PREAMBLE_EN
    localparam int PRE_W = $clog2(PREAMBLE_SYMS + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PREAMBLE_SYMS - 1);
    logic [PRE_W-1:0] pre_cnt;
`endif

    crc_fsk4_crc #(
        .DATA_W   (DATA_W),
        .CRC_W    (CRC_W),
        .CRC_POLY (CRC_POLY)
    ) u_crc (
        .crc_in  ((state == IDLE) ? CRC_INIT : crc_reg),
        .data_in (in_data),
        .crc_out (crc_next)
    );

    // Words and CRC are MSB-aligned so the next dibit is always the top two bits.
    assign word_al  = SR_W'(in_data) << (SR_W - DATA_W);
    assign crc_al   = SR_W'(crc_reg ^ CRC_XOROUT) << (SR_W - CRC_W);
    assign out_fire = out_valid & out_ready;
    assign in_fire  = in_valid & in_ready;
    assign in_ready = (state == IDLE) ||
                      ((state == DATA) &&
                       (!out_valid || (out_fire && (sym_cnt == SYM_ONE) && !last_word)));
    assign out_last = out_valid && (state == CRC) && (sym_cnt == SYM_ONE);

`ifdef CRC_FSK_PREAMBLE_EN
    assign out_tone = (state == PRE) ? (pre_cnt[0] ? TONE_3 : TONE_0) : gray_map(sr[SR_W-1 -: 2]);
`else
    assign out_tone = gray_map(sr[SR_W-1 -: 2]);
`endif

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sr        <= '0;
            sym_cnt   <= '0;
            last_word <= 1'b0;
            out_valid <= 1'b0;
            crc_reg   <= CRC_INIT;
            crc_value <= '0;
            busy      <= 1'b0;
`ifdef CRC_FSK_PREAMBLE_EN
            pre_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (in_fire) begin
                    sr        <= word_al;
                    sym_cnt   <= SYM_DATA;
                    last_word <= in_last;
                    crc_reg   <= crc_next;
                    out_valid <= 1'b1;
                    busy      <= 1'b1;
`ifdef CRC_FSK_PREAMBLE_EN
                    pre_cnt   <= '0;
                    state     <= PRE;
`else
                    state     <= DATA;
`endif
                end
`ifdef CRC_FSK_PREAMBLE_EN
                PRE: if (out_fire) begin
                    if (pre_cnt == PRE_LAST) state <= DATA;
                    else                     pre_cnt <= pre_cnt + 1'b1;
                end
`endif
                DATA: if (in_fire) begin
                    sr        <= word_al;
                    sym_cnt   <= SYM_DATA;
                    last_word <= in_last;
                    crc_reg   <= crc_next;
                    out_valid <= 1'b1;
                end else if (out_fire) begin
                    if (sym_cnt == SYM_ONE) begin
                        if (last_word) begin
                            sr      <= crc_al;
                            sym_cnt <= SYM_CRC;
                            state   <= CRC;
                        end else begin
                            // Source has not supplied the next word yet: stall the line.
                            out_valid <= 1'b0;
                        end
                    end else begin
                        sr      <= sr << 2;
                        sym_cnt <= sym_cnt - SYM_ONE;
                    end
                end
                CRC: if (out_fire) begin
                    if (sym_cnt == SYM_ONE) begin
                        crc_value <= crc_reg ^ CRC_XOROUT;
                        crc_reg   <= CRC_INIT;
                        sr        <= '0;
                        sym_cnt   <= '0;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        sr      <= sr << 2;
                        sym_cnt <= sym_cnt - SYM_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_fsk4_framer.sv
// Directed bench for crc_fsk4_framer: 8-bit CRC-8/0x07 instance driven from a vector table plus reset and
// CRC-16/CCITT-FALSE sequences on a 16-bit instance. Preamble expectations follow CRC_FSK_PREAMBLE_EN.
module tb_crc_fsk4_framer;

`ifdef CRC_FSK_PREAMBLE_EN
    localparam int PRE_N = 4;
`else
    localparam int PRE_N = 0;
`endif

    logic        sys_clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid, in_last, in_ready;
    logic [1:0]  out_tone;
    logic        out_valid, out_last, out_ready;
    logic [7:0]  crc_value;
    logic        busy;

    logic [15:0] w_in_data;
    logic        w_in_valid, w_in_last, w_in_ready;
    logic [1:0]  w_out_tone;
    logic        w_out_valid, w_out_last, w_out_ready;
    logic [15:0] w_crc_value;
    logic        w_busy;

    int checks = 0;
    int errors = 0;

    crc_fsk4_framer #(
        .DATA_W(8), .CRC_W(8), .CRC_POLY(8'h07), .CRC_INIT(8'h00),
        .CRC_XOROUT(8'h00), .PREAMBLE_SYMS(4)
    ) u_dut8 (
        .sys_clk(sys_clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_tone(out_tone), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .crc_value(crc_value), .busy(busy)
    );

    crc_fsk4_framer #(
        .DATA_W(16), .CRC_W(16), .CRC_POLY(16'h1021), .CRC_INIT(16'hFFFF),
        .CRC_XOROUT(16'h0000), .PREAMBLE_SYMS(4)
    ) u_dut16 (
        .sys_clk(sys_clk), .reset(reset),
        .in_data(w_in_data), .in_valid(w_in_valid), .in_last(w_in_last), .in_ready(w_in_ready),
        .out_tone(w_out_tone), .out_valid(w_out_valid), .out_last(w_out_last), .out_ready(w_out_ready),
        .crc_value(w_crc_value), .busy(w_busy)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "global timeout");
    end

    // words: word k at [15-8k -: 8]; tones: symbol k at [23-2k -: 2].
    typedef struct packed {
        logic [1:0]  nwords;
        logic [15:0] words;
        logic [4:0]  nsym;
        logic [23:0] tones;
        logic [7:0]  crc;
        logic        toggle;
        logic        gap;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] exp_tone(input vec_t v, input int k);
        if (k < PRE_N) return (k % 2 == 1) ? 2'd3 : 2'd0;
        return v.tones[23 - 2*(k - PRE_N) -: 2];
    endfunction

    function automatic logic [1:0] tone_of(input logic [1:0] d);
        case (d)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    task automatic run_vec(input vec_t v, input int id);
        int  widx, nsym, cyc, bubbles, gap_left, total;
        bit  started, done, acc_prev;
        logic [1:0] et;
        total = int'(v.nsym) + PRE_N;
        widx = 0; nsym = 0; cyc = 0; bubbles = 0; gap_left = 0;
        started = 0; done = 0; acc_prev = 0;
        while (!done && cyc < 400) begin
            @(negedge sys_clk);
            in_valid  = (widx < int'(v.nwords)) && (gap_left == 0);
            in_data   = (widx < 2) ? v.words[15 - 8*widx -: 8] : 8'h00;
            in_last   = (widx == int'(v.nwords) - 1);
            out_ready = v.toggle ? (cyc % 2 == 0) : 1'b1;
            #1;
            if (acc_prev) begin
                chk($sformatf("v%0d latency out_valid after accept", id), out_valid, 1);
                acc_prev = 0;
            end
            if (out_valid) begin
                started = 1;
                et = exp_tone(v, nsym);
                chk($sformatf("v%0d tone[%0d]", id, nsym), out_tone, et);
                chk($sformatf("v%0d out_last[%0d]", id, nsym), out_last, (nsym == total - 1));
                chk($sformatf("v%0d busy[%0d]", id, nsym), busy, 1);
`ifdef CRC_FSK_PREAMBLE_EN
                if (nsym < PRE_N) chk($sformatf("v%0d in_ready in preamble", id), in_ready, 0);
`endif
            end else if (started) begin
                bubbles++;
            end
            if (out_valid && out_ready) begin
                nsym++;
                if (nsym == total) done = 1;
            end
            if (in_valid && in_ready) begin
                widx++;
                acc_prev = 1;
                if (v.gap) gap_left = 3;
            end else if (gap_left > 0) begin
                gap_left--;
            end
            cyc++;
        end
        in_valid = 1'b0;
        chk($sformatf("v%0d symbols before timeout", id), nsym, total);
        if (!v.gap) chk($sformatf("v%0d bubbles", id), bubbles, 0);
        @(posedge sys_clk);
        #1;
        chk($sformatf("v%0d crc_value", id), crc_value, v.crc);
        chk($sformatf("v%0d busy after frame", id), busy, 0);
        chk($sformatf("v%0d out_valid after frame", id), out_valid, 0);
    endtask

    initial begin
        logic [15:0] w_words[5];
        logic [15:0] crc16_tones;
        logic [15:0] wd;
        logic [1:0]  et;
        int  cnt, widx, n, k, total16;
        bit  acc;

        vecs[0] = '{nwords: 2'd1, words: 16'hBB00, nsym: 5'd8,
                    tones: {2'd3,2'd2,2'd3,2'd2, 2'd0,2'd3,2'd3,2'd0, 8'h00}, crc: 8'h28, toggle: 1'b0, gap: 1'b0};
        vecs[1] = '{nwords: 2'd2, words: 16'hBB00, nsym: 5'd12,
                    tones: {2'd3,2'd2,2'd3,2'd2, 2'd0,2'd0,2'd0,2'd0, 2'd2,2'd1,2'd3,2'd0}, crc: 8'hD8, toggle: 1'b0, gap: 1'b0};
        vecs[2] = '{nwords: 2'd1, words: 16'hBB00, nsym: 5'd8,
                    tones: {2'd3,2'd2,2'd3,2'd2, 2'd0,2'd3,2'd3,2'd0, 8'h00}, crc: 8'h28, toggle: 1'b1, gap: 1'b0};
        vecs[3] = '{nwords: 2'd1, words: 16'h0000, nsym: 5'd8,
                    tones: {2'd0,2'd0,2'd0,2'd0, 2'd0,2'd0,2'd0,2'd0, 8'h00}, crc: 8'h00, toggle: 1'b0, gap: 1'b0};
        vecs[4] = '{nwords: 2'd1, words: 16'hFF00, nsym: 5'd8,
                    tones: {2'd2,2'd2,2'd2,2'd2, 2'd2,2'd2,2'd0,2'd2, 8'h00}, crc: 8'hF3, toggle: 1'b0, gap: 1'b0};
        vecs[5] = '{nwords: 2'd1, words: 16'h1E00, nsym: 5'd8,
                    tones: {2'd0,2'd1,2'd2,2'd3, 2'd1,2'd1,2'd3,2'd3, 8'h00}, crc: 8'h5A, toggle: 1'b0, gap: 1'b0};
        vecs[6] = '{nwords: 2'd2, words: 16'hBB00, nsym: 5'd12,
                    tones: {2'd3,2'd2,2'd3,2'd2, 2'd0,2'd0,2'd0,2'd0, 2'd2,2'd1,2'd3,2'd0}, crc: 8'hD8, toggle: 1'b1, gap: 1'b1};

        reset = 1'b1;
        in_data = '0; in_valid = 0; in_last = 0; out_ready = 0;
        w_in_data = '0; w_in_valid = 0; w_in_last = 0; w_out_ready = 0;
        #3;
        chk("reset out_valid", out_valid, 0);
        chk("reset out_last", out_last, 0);
        chk("reset out_tone", out_tone, 0);
        chk("reset busy", busy, 0);
        chk("reset crc_value", crc_value, 0);
        chk("reset w16 out_valid", w_out_valid, 0);
        chk("reset w16 crc_value", w_crc_value, 0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Mid-frame reset after two consumed symbols, then a clean repeat of the single-word frame.
        acc = 0; cnt = 0;
        for (int c = 0; c < 30 && cnt < 2; c++) begin
            @(negedge sys_clk);
            in_valid = !acc; in_data = 8'hBB; in_last = 1'b1; out_ready = 1'b1;
            #1;
            if (in_valid && in_ready) acc = 1;
            if (out_valid && out_ready) cnt++;
        end
        chk("midreset symbols before reset", cnt, 2);
        @(posedge sys_clk);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("midreset out_valid", out_valid, 0);
        chk("midreset out_last", out_last, 0);
        chk("midreset out_tone", out_tone, 0);
        chk("midreset busy", busy, 0);
        chk("midreset crc_value", crc_value, 0);
        @(negedge sys_clk);
        reset = 1'b0;
        run_vec(vecs[0], 10);

        // CRC-16/CCITT-FALSE over "123456789" plus one zero pad byte: 0x29B1 advanced by 0x00 gives 0x044B.
        w_words[0] = 16'h3132; w_words[1] = 16'h3334; w_words[2] = 16'h3536;
        w_words[3] = 16'h3738; w_words[4] = 16'h3900;
        crc16_tones = {2'd0,2'd0,2'd1,2'd0,2'd1,2'd0,2'd3,2'd2};
        total16 = 40 + 8 + PRE_N;
        widx = 0; n = 0;
        for (int c = 0; c < 300 && n < total16; c++) begin
            @(negedge sys_clk);
            w_in_valid  = (widx < 5);
            w_in_data   = (widx < 5) ? w_words[widx] : 16'h0000;
            w_in_last   = (widx == 4);
            w_out_ready = 1'b1;
            #1;
            if (w_out_valid && w_out_ready) begin
                k = n - PRE_N;
                if (k >= 40) begin
                    et = crc16_tones[15 - 2*(k - 40) -: 2];
                    chk($sformatf("w16 crc tone[%0d]", k - 40), w_out_tone, et);
                end else if (k >= 0) begin
                    wd = w_words[k / 8];
                    et = tone_of(2'(wd >> (14 - 2*(k % 8))));
                    chk($sformatf("w16 data tone[%0d]", k), w_out_tone, et);
                end
                chk($sformatf("w16 out_last[%0d]", n), w_out_last, (n == total16 - 1));
                n++;
            end
            if (w_in_valid && w_in_ready) widx++;
        end
        w_in_valid = 1'b0;
        chk("w16 symbol count", n, total16);
        @(posedge sys_clk);
        #1;
        chk("w16 crc_value", w_crc_value, 16'h044B);
        chk("w16 busy after frame", w_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
